// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB word-memory slave.
// Width helpers are functions so that each instance derives its own values from its DATA_W.
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  function automatic int strb_w(int data_w);
    return data_w / 8;
  endfunction

  function automatic int align_w(int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Flags misaligned, out-of-range, or read-only-window write accesses
  function automatic logic access_err(logic [31:0] addr, int aw, int depth,
                                      int ro_base, logic wr);
    logic [31:0] idx;
    logic        mis;
    idx = addr >> aw;
    mis = (addr & ((32'd1 << aw) - 32'd1)) != 32'd0;
    return mis || (idx >= 32'(depth)) || (wr && (idx >= 32'(ro_base)));
  endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB bus bundle between a master and the word-memory slave.
interface apb_mem_slave_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_mem_array.sv
// Word storage with byte-enable synchronous write and combinational read.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int MEM_AW = 6
) (
  input  logic                       pclk,
  input  logic                       we,
  input  logic [MEM_AW-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [strb_w(DATA_W)-1:0]  wstrb,
  input  logic [MEM_AW-1:0]          raddr,
  output logic [DATA_W-1:0]          rdata
);
  localparam int STRB_W = strb_w(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge pclk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/apb_mem_slave.sv
// APB slave in front of a word memory: wait states, byte strobes, error response.
// state  | meaning
// IDLE   | waiting for a setup phase; pready/pslverr low
// WAIT   | counting down inserted wait states while penable is high
// ACCESS | pready high; transfer completes on psel & penable
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int WAIT_W  = 4,
  parameter int RO_BASE = 48
) (
  input  logic              pclk,
  input  logic              preset,
  apb_mem_slave_if.slave    bus,
  input  logic [WAIT_W-1:0] wait_cfg,
  output logic [1:0]        state_o
);
  localparam int ALIGN_W = align_w(DATA_W);
  localparam int MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                err_q, err_d;
  logic [MEM_AW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic [DATA_W-1:0]   rd_data;
  logic [MEM_AW-1:0]   rd_idx;
  logic                wr_en;

  // Out-of-range indices are truncated here but always flagged by err, so never used
  assign rd_idx = MEM_AW'(bus.paddr >> ALIGN_W);
  assign wr_en  = (state_q == ACCESS) && bus.psel && bus.penable && bus.pwrite && !err_q;

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .MEM_AW (MEM_AW)
  ) u_array (
    .pclk  (pclk),
    .we    (wr_en),
    .waddr (idx_q),
    .wdata (bus.pwdata),
    .wstrb (bus.pstrb),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    idx_d      = idx_q;
    prdata_d   = prdata_q;
    case (state_q)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          idx_d      = rd_idx;
          wait_cnt_d = wait_cfg;
          err_d      = access_err(32'(bus.paddr), ALIGN_W, DEPTH, RO_BASE, bus.pwrite);
          if (!bus.pwrite) prdata_d = err_d ? '0 : rd_data;
          state_d    = (wait_cfg != '0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (!bus.psel) begin
          state_d = IDLE;
        end else if (bus.penable) begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
          if (wait_cnt_q == WAIT_W'(1)) state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.psel || bus.penable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      prdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      prdata_q   <= prdata_d;
    end
  end

  assign bus.pready  = (state_q == ACCESS);
  assign bus.pslverr = (state_q == ACCESS) && err_q;
  assign bus.prdata  = prdata_q;
  assign state_o     = state_q;
endmodule
